logicnet_lut_layer: RTL and testbench

Parametrised, pipelined LogicNet layer: `N_NEURONS` neuron truth tables, each mapping an `IN_BITS`-bit fan-in address to an `OUT_BITS`-bit quantised activation. It supersedes the single fixed-ROM, purely combinational neuron module. Tables are writable at run time, so retrained weights can be loaded without resynthesis. Lookups pass through a registered valid/ready stage, so layers chain directly into a pipelined network between feature input and classifier output.

---
 rtl/logicnet_lut_layer.sv | 61 ++++++
 tb/tb_logicnet_lut_layer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/logicnet_lut_layer.sv
// logicnet_lut_layer: run-time writable LUT neuron layer with a registered valid/ready output stage.
// Each neuron maps its IN_BITS address slice to an OUT_BITS activation held in flop-based tables.
module logicnet_lut_layer #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 6,
    parameter int OUT_BITS  = 2,
    parameter int NIDX_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_we,
    input  logic [NIDX_W-1:0]             cfg_neuron,
    input  logic [IN_BITS-1:0]            cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic                          cfg_err,
    output logic [15:0]                   lookup_cnt
);
    localparam int DEPTH = 2 ** IN_BITS;
    logic [OUT_BITS-1:0]           tbl [N_NEURONS][DEPTH];
    logic [N_NEURONS*OUT_BITS-1:0] lut;
    logic                          accept;
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    always_comb begin
        lut = '0;
        for (int k = 0; k < N_NEURONS; k++)
            lut[k*OUT_BITS +: OUT_BITS] = tbl[k][in_data[k*IN_BITS +: IN_BITS]];
    end
    // A same-cycle write lands at the edge that registers the lookup, so the lookup sees the old entry.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++)
                for (int a = 0; a < DEPTH; a++)
                    tbl[k][a] <= '0;
        end else if (cfg_we) begin
            for (int k = 0; k < N_NEURONS; k++)
                if (cfg_neuron == NIDX_W'(k)) tbl[k][cfg_addr] <= cfg_data;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cfg_err <= 1'b0;
        else if (cfg_we && int'(cfg_neuron) >= N_NEURONS) cfg_err <= 1'b1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lut;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) lookup_cnt <= '0;
        else if (out_valid && out_ready) lookup_cnt <= lookup_cnt + 16'd1;
endmodule

// File: tb/tb_logicnet_lut_layer.sv
// tb_logicnet_lut_layer: directed vectors for the LUT layer, plus a 3-neuron instance for the config error path.
module tb_logicnet_lut_layer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_data;
    logic [7:0]  out_data;
    logic        cfg_we, cfg_err;
    logic [1:0]  cfg_neuron, cfg_data;
    logic [5:0]  cfg_addr;
    logic [15:0] lookup_cnt;
    logic        in_ready3, out_valid3, cfg_err3;
    logic [5:0]  out_data3;
    logic [15:0] lookup_cnt3;
    int          nvec = 0;
    int          nerr = 0;

    always #5 clk = ~clk;

    logicnet_lut_layer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .cfg_we(cfg_we),
        .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .lookup_cnt(lookup_cnt)
    );

    logicnet_lut_layer #(.N_NEURONS(3), .IN_BITS(6), .OUT_BITS(2), .NIDX_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data[17:0]),
        .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .cfg_we(cfg_we),
        .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err3),
        .lookup_cnt(lookup_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wr(input logic [1:0] n, input logic [5:0] a, input logic [1:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_neuron = n; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic look(input logic [23:0] d, input logic [7:0] want, input string tag);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_data), 32'(want));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_cnt", 32'(lookup_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        look(24'h0, 8'h00, "zero");
        @(negedge clk);
        chk("first_cnt", 32'(lookup_cnt), 32'd1);
        chk("first_drain", 32'(out_valid), 32'd0);

        wr(2'd0, 6'h00, 2'b01);
        look(24'h000000, 8'h01, "n0_a00");
        look(24'h000020, 8'h00, "n0_a20");
        wr(2'd3, 6'h00, 2'b11);
        chk("err3_set", 32'(cfg_err3), 32'd1);
        chk("err4_clear", 32'(cfg_err), 32'd0);
        look(24'h000000, 8'hC1, "n3_a00");
        chk("n3_no_change", 32'(out_data3), 32'h01);
        look(24'h800000, 8'h01, "n3_a20");

        // Backpressure: word A (0xC1) stalls, word B (neuron0 addr 1 -> 0xC0) waits behind it.
        @(negedge clk);
        in_valid = 1'b1; in_data = 24'h0; out_ready = 1'b0;
        @(negedge clk);
        in_data = 24'h000001;
        chk("bp_cnt_before", 32'(lookup_cnt), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", 32'(out_data), 32'hC1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b_valid", 32'(out_valid), 32'd1);
        chk("bp_b_data", 32'(out_data), 32'hC0);
        @(negedge clk);
        chk("bp_cnt_after", 32'(lookup_cnt), 32'd7);
        chk("bp_drain", 32'(out_valid), 32'd0);

        wr(2'd1, 6'h2A, 2'b10);
        @(negedge clk);
        cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'h2A; cfg_data = 2'b01;
        in_valid = 1'b1; in_data = 24'h000A80; out_ready = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("hazard_old", 32'(out_data), 32'hC9);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hazard_new", 32'(out_data), 32'hC5);

        @(negedge clk);
        in_valid = 1'b1; in_data = 24'h0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wr(2'd0, 6'h00, 2'b10);
        chk("stall_wr_valid", 32'(out_valid), 32'd1);
        chk("stall_wr_hold", 32'(out_data), 32'hC1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_wr_cnt", 32'(lookup_cnt), 32'd10);
        look(24'h0, 8'hC2, "after_wr");
        chk("err3_sticky", 32'(cfg_err3), 32'd1);

        @(negedge clk);
        in_valid = 1'b1; in_data = 24'h0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_cnt", 32'(lookup_cnt), 32'd0);
        chk("mid_rst_err3", 32'(cfg_err3), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        look(24'h0, 8'h00, "table_lost");
        @(negedge clk);
        chk("post_rst_cnt", 32'(lookup_cnt), 32'd1);

        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 70000 && lookup_cnt != 16'hFFFF; i++) @(negedge clk);
        chk("cnt_max", 32'(lookup_cnt), 32'hFFFF);
        in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_wrap", 32'(lookup_cnt), 32'd0);
        chk("wrap_drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
